// File: rtl/alu_shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_shift_pkg
// Description : Shared op encodings and FSM state type for the sequential
//               shift/rotate ALU unit.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_shift_pkg;

    localparam logic [2:0] OP_SHL = 3'b000;
    localparam logic [2:0] OP_SHR = 3'b001;
    localparam logic [2:0] OP_SAR = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : alu_shift_pkg
`default_nettype wire

// File: rtl/alu_shift_step.sv
`default_nettype none
// ============================================================================
// Module      : alu_shift_step
// Description : Combinational single-position shift/rotate step. Produces
//               the next working value and the bit moved out of it.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_shift_step
    import alu_shift_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] r,
    input  logic [2:0]   op,
    output logic [N-1:0] r_nxt,
    output logic         carry_out
);

    // One-position move selected by op; pass-through ops leave r unchanged
    always_comb begin
        r_nxt     = r;
        carry_out = 1'b0;
        case (op)
            OP_SHL: begin
                r_nxt     = {r[N-2:0], 1'b0};
                carry_out = r[N-1];
            end
            OP_SHR: begin
                r_nxt     = {1'b0, r[N-1:1]};
                carry_out = r[0];
            end
            OP_SAR: begin
                r_nxt     = {r[N-1], r[N-1:1]};
                carry_out = r[0];
            end
            OP_ROL: begin
                r_nxt     = {r[N-2:0], r[N-1]};
                carry_out = r[N-1];
            end
            OP_ROR: begin
                r_nxt     = {r[0], r[N-1:1]};
                carry_out = r[0];
            end
            default: begin
                r_nxt     = r;
                carry_out = 1'b0;
            end
        endcase
    end

endmodule : alu_shift_step
`default_nettype wire

// File: rtl/alu_shift_seq_nbit.sv
`default_nettype none
// ============================================================================
// Module      : alu_shift_seq_nbit
// Description : Iterative N-bit shift/rotate unit with carry/zero flags and a
//               start/busy/done handshake. One bit position per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_shift_seq_nbit
    import alu_shift_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] R,
    output logic         carry,
    output logic         zero,
    output logic         busy,
    output logic         done
);

    // Shift amount width; wide enough to hold N and rotate counts up to 2N-1
    localparam int SW = $clog2(N) + 1;
    localparam logic [SW-1:0] c_max_shift = SW'(N);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [N-1:0]  r_work;
    logic [2:0]    r_op;
    logic [SW-1:0] r_cnt;
    logic          r_carry;

    logic [SW-1:0] w_k;
    logic [SW-1:0] w_eff_cnt;
    logic          w_accept;
    logic [N-1:0]  w_step_r;
    logic          w_step_c;

    // Shift amount taken from the low bits of B, zero-extended for narrow B
    generate
        if (N >= SW) begin : g_k_slice
            assign w_k = B[SW-1:0];
        end else begin : g_k_zext
            assign w_k = {{(SW-N){1'b0}}, B};
        end
    endgenerate

    // Shifts saturate at N (same result as a full shift); rotates run k steps
    always_comb begin
        w_eff_cnt = '0;
        case (op)
            OP_SHL, OP_SHR, OP_SAR: w_eff_cnt = (w_k > c_max_shift) ? c_max_shift : w_k;
            OP_ROL, OP_ROR:         w_eff_cnt = w_k;
            default:                w_eff_cnt = '0;
        endcase
    end

    // A new request is taken whenever no shift is in flight, including DONE
    assign w_accept = start && (r_state != ST_SHIFT);

    alu_shift_step #(
        .N (N)
    ) u_step (
        .r         (r_work),
        .op        (r_op),
        .r_nxt     (w_step_r),
        .carry_out (w_step_c)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: zero-count requests skip SHIFT and land in DONE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = (w_eff_cnt == '0) ? ST_DONE : ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == SW'(1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: capture operands on accept, then one step per SHIFT cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_work  <= '0;
            r_op    <= OP_SHL;
            r_cnt   <= '0;
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_work  <= A;
            r_op    <= op;
            r_cnt   <= w_eff_cnt;
            r_carry <= 1'b0;
        end else if (r_state == ST_SHIFT) begin
            r_work  <= w_step_r;
            r_carry <= w_step_c;
            r_cnt   <= r_cnt - SW'(1);
        end
    end

    assign R     = r_work;
    assign carry = r_carry;
    assign zero  = (r_work == '0);
    assign busy  = (r_state == ST_SHIFT);
    assign done  = (r_state == ST_DONE);

endmodule : alu_shift_seq_nbit
`default_nettype wire

// File: tb/tb_alu_shift_seq_nbit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_shift_seq_nbit
// Description : Scoreboard bench for alu_shift_seq_nbit. Expected results come
//               from an arithmetic reference model; a monitor checks each done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_shift_seq_nbit;

    localparam int N  = 3;
    localparam int SW = $clog2(N) + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] R;
    logic         carry;
    logic         zero;
    logic         busy;
    logic         done;

    typedef struct {
        logic [N-1:0] r;
        logic         c;
        int           cnt;
        int           due;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;

    alu_shift_seq_nbit #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .R     (R),
        .carry (carry),
        .zero  (zero),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    // Edge counter used to time done pulses
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: whole-amount arithmetic shifts and modular rotates
    function automatic exp_t model(input logic [2:0] o, input logic [N-1:0] a_i,
                                   input logic [N-1:0] b_i);
        exp_t e;
        int   a    = int'(a_i);
        int   mask = (1 << N) - 1;
        int   k    = int'(b_i) & ((1 << SW) - 1);
        int   s    = (k > N) ? N : k;
        int   sx   = a_i[N-1] ? (a - (1 << N)) : a;
        int   m    = k % N;
        int   res;
        int   cb;
        case (o)
            3'd0: begin res = (a << s) & mask;        cb = (s != 0) ? ((a >> (N - s)) & 1) : 0; e.cnt = s; end
            3'd1: begin res = a >> s;                 cb = (s != 0) ? ((a >> (s - 1)) & 1) : 0; e.cnt = s; end
            3'd2: begin res = (sx >>> s) & mask;      cb = (s != 0) ? ((sx >>> (s - 1)) & 1) : 0; e.cnt = s; end
            3'd3: begin res = ((a << m) | (a >> (N - m))) & mask; cb = (k != 0) ? (res & 1) : 0; e.cnt = k; end
            3'd4: begin res = ((a >> m) | (a << (N - m))) & mask; cb = (k != 0) ? ((res >> (N - 1)) & 1) : 0; e.cnt = k; end
            default: begin res = a; cb = 0; e.cnt = 0; end
        endcase
        e.r   = N'(res);
        e.c   = cb[0];
        e.due = 0;
        return e;
    endfunction

    // Monitor: compare every done pulse against the oldest expectation
    always @(negedge clk) begin
        if (!rst) begin
            check("busy_done_excl", int'(busy && done), 0);
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    mon_e = q.pop_front();
                    check("R", int'(R), int'(mon_e.r));
                    check("carry", int'(carry), int'(mon_e.c));
                    check("zero", int'(zero), int'(mon_e.r == '0));
                    check("done_cycle", cyc, mon_e.due);
                end
            end
        end
    end

    // Issue one request at a negedge once the unit is not busy; optionally
    // keep start high with junk operands for the whole busy window
    task automatic issue(input logic [2:0] o, input logic [N-1:0] a_i,
                         input logic [N-1:0] b_i, input bit hold_junk);
        exp_t e;
        int   n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("wait_not_busy", 1, 0);
        e     = model(o, a_i, b_i);
        e.due = cyc + 1 + e.cnt;
        q.push_back(e);
        start = 1'b1;
        op    = o;
        A     = a_i;
        B     = b_i;
        @(negedge clk);
        if (hold_junk) begin
            op = 3'(o + 3'd1);
            A  = ~a_i;
            B  = ~b_i;
            n  = 0;
            while (busy && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) check("drain_timeout", q.size(), 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        A     = '0;
        B     = '0;
        repeat (2) @(negedge clk);
        check("rst_R", int'(R), 0);
        check("rst_zero", int'(zero), 1);
        check("rst_carry", int'(carry), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        issue(3'b000, 3'b011, 3'b001, 1'b0); drain();
        issue(3'b000, 3'b111, 3'b101, 1'b0); drain();
        issue(3'b001, 3'b101, 3'b010, 1'b0); drain();
        issue(3'b010, 3'b100, 3'b010, 1'b0); drain();
        issue(3'b011, 3'b101, 3'b100, 1'b0); drain();
        issue(3'b100, 3'b001, 3'b001, 1'b0); drain();
        issue(3'b000, 3'b110, 3'b000, 1'b0); drain();
        issue(3'b110, 3'b101, 3'b011, 1'b0); drain();

        // Start held through busy with different operands is ignored
        issue(3'b011, 3'b110, 3'b111, 1'b1); drain();

        // Back-to-back: second start lands in the DONE cycle of the first
        issue(3'b001, 3'b111, 3'b011, 1'b0);
        issue(3'b100, 3'b011, 3'b010, 1'b0);
        issue(3'b111, 3'b010, 3'b001, 1'b0);
        issue(3'b000, 3'b001, 3'b001, 1'b0);
        drain();

        // Reset on edge 2 of a 3-step SHL aborts it
        issue(3'b000, 3'b111, 3'b011, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        q.delete();
        check("abort_R", int'(R), 0);
        check("abort_zero", int'(zero), 1);
        check("abort_carry", int'(carry), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(3'b000, 3'b011, 3'b010, 1'b0); drain();

        // Randomized traffic with occasional idle gaps
        repeat (150) begin
            issue(3'($urandom_range(0, 7)), N'($urandom_range(0, (1 << N) - 1)),
                  N'($urandom_range(0, (1 << N) - 1)), 1'b0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_alu_shift_seq_nbit
`default_nettype wire
